// File: rtl/fc_ibuf_loader_if.sv
`default_nettype none
// fc_ibuf_loader_if : producer func stream, consumer ibuf write port and layer launch handshake.
// Rev 1.0
interface fc_ibuf_loader_if #(
  parameter int IN_DATATYPE_SIZE = 8,
  parameter int DATATYPE_SIZE    = 8,
  parameter int ADDR_W           = 8
);
  logic                        i_func_valid;
  logic [IN_DATATYPE_SIZE-1:0] i_func_data;
  logic                        o_next_busy;
  logic                        o_ibuf_we;
  logic [DATATYPE_SIZE-1:0]    o_ibuf_wr_data;
  logic [ADDR_W-1:0]           o_ibuf_addr;
  logic                        o_start;
  logic                        i_layer_busy;
  logic [15:0]                 o_frame_cnt;
  logic                        o_drop;

  modport slave (
    input  i_func_valid, i_func_data, i_layer_busy,
    output o_next_busy, o_ibuf_we, o_ibuf_wr_data, o_ibuf_addr,
           o_start, o_frame_cnt, o_drop
  );

  modport master (
    output i_func_valid, i_func_data, i_layer_busy,
    input  o_next_busy, o_ibuf_we, o_ibuf_wr_data, o_ibuf_addr,
           o_start, o_frame_cnt, o_drop
  );
endinterface
`default_nettype wire

// File: rtl/fc_ibuf_loader.sv
`default_nettype none
// fc_ibuf_loader : collects one frame of func beats, saturates/ReLUs them into the ibuf, launches the layer.
// Rev 1.0
module fc_ibuf_loader #(
  parameter int INPUT_SIZE       = 256,
  parameter int IN_DATATYPE_SIZE = 8,
  parameter int DATATYPE_SIZE    = 8,
  parameter int RELU_EN          = 0
) (
  input  wire logic       clk,
  input  wire logic       rst,
  fc_ibuf_loader_if.slave bus
);

  localparam int ADDR_W = $clog2(INPUT_SIZE);
  localparam logic signed [IN_DATATYPE_SIZE-1:0] SAT_MAX =
    IN_DATATYPE_SIZE'((2 ** (DATATYPE_SIZE - 1)) - 1);
  localparam logic signed [IN_DATATYPE_SIZE-1:0] SAT_MIN =
    IN_DATATYPE_SIZE'(-(2 ** (DATATYPE_SIZE - 1)));
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(INPUT_SIZE - 1);

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t                              state;
  state_t                              state_nxt;
  logic [ADDR_W-1:0]                   count;
  logic [ADDR_W-1:0]                   count_nxt;
  logic                                accept;
  logic                                start_nxt;
  logic signed [IN_DATATYPE_SIZE-1:0]  relu_val;
  logic [DATATYPE_SIZE-1:0]            conv_val;

  // Element conversion: optional ReLU, then clamp into the consumer's signed range.
  always_comb begin
    relu_val = $signed(bus.i_func_data);
    if ((RELU_EN != 0) && relu_val[IN_DATATYPE_SIZE-1]) begin
      relu_val = '0;
    end
    if (relu_val > SAT_MAX) begin
      conv_val = SAT_MAX[DATATYPE_SIZE-1:0];
    end else if (relu_val < SAT_MIN) begin
      conv_val = SAT_MIN[DATATYPE_SIZE-1:0];
    end else begin
      conv_val = relu_val[DATATYPE_SIZE-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    accept    = 1'b0;
    start_nxt = 1'b0;
    case (state)
      FILL: begin
        if (bus.i_func_valid) begin
          accept = 1'b1;
          if (count == LAST_IDX) begin
            count_nxt = '0;
            state_nxt = LAUNCH;
          end else begin
            count_nxt = count + ADDR_W'(1);
          end
        end
      end
      LAUNCH: begin
        start_nxt = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      // Busy seen while filling is stale from the previous frame and deliberately not tracked.
      WAIT_BUSY: begin
        if (bus.i_layer_busy) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.i_layer_busy) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.o_next_busy    <= 1'b0;
      bus.o_ibuf_we      <= 1'b0;
      bus.o_ibuf_wr_data <= '0;
      bus.o_ibuf_addr    <= '0;
      bus.o_start        <= 1'b0;
      bus.o_frame_cnt    <= '0;
      bus.o_drop         <= 1'b0;
    end else begin
      bus.o_next_busy <= (state_nxt != FILL);
      bus.o_ibuf_we   <= accept;
      if (accept) begin
        bus.o_ibuf_addr    <= count;
        bus.o_ibuf_wr_data <= conv_val;
      end
      bus.o_start <= start_nxt;
      if (start_nxt) begin
        bus.o_frame_cnt <= bus.o_frame_cnt + 16'd1;
      end
      if (bus.i_func_valid && bus.o_next_busy) begin
        bus.o_drop <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_ibuf_loader.sv
`default_nettype none
// tb_fc_ibuf_loader : directed and randomized checks of fc_ibuf_loader against a frame-level model.
// Rev 1.0
module tb_fc_ibuf_loader;

  localparam int N = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_wr_cyc = 0;
  int   wa_q[$];
  int   wd_q[$];
  int   st_q[$];
  int   exp_q[$];
  int   sat_v[4] = '{300, -300, -5, 7};

  always #5 clk = ~clk;

  fc_ibuf_loader_if #(.IN_DATATYPE_SIZE(8),  .DATATYPE_SIZE(8), .ADDR_W(8)) a ();
  fc_ibuf_loader_if #(.IN_DATATYPE_SIZE(16), .DATATYPE_SIZE(8), .ADDR_W(2)) s ();
  fc_ibuf_loader_if #(.IN_DATATYPE_SIZE(16), .DATATYPE_SIZE(8), .ADDR_W(2)) r ();

  fc_ibuf_loader #(.INPUT_SIZE(N), .IN_DATATYPE_SIZE(8), .DATATYPE_SIZE(8), .RELU_EN(0))
    dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  fc_ibuf_loader #(.INPUT_SIZE(4), .IN_DATATYPE_SIZE(16), .DATATYPE_SIZE(8), .RELU_EN(0))
    dut_s (.clk(clk), .rst(rst), .bus(s.slave));
  fc_ibuf_loader #(.INPUT_SIZE(4), .IN_DATATYPE_SIZE(16), .DATATYPE_SIZE(8), .RELU_EN(1))
    dut_r (.clk(clk), .rst(rst), .bus(r.slave));

  // Reference conversion on plain integers; result is the dw-bit pattern.
  function automatic int conv(input int x, input int dw, input bit relu);
    int v;
    int hi;
    int lo;
    v  = x;
    hi = (1 << (dw - 1)) - 1;
    lo = -(1 << (dw - 1));
    if (relu && v < 0) v = 0;
    if (v > hi) v = hi;
    if (v < lo) v = lo;
    return v & ((1 << dw) - 1);
  endfunction

  function automatic int s8(input int b);
    return (b >= 128) ? b - 256 : b;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (a.o_ibuf_we) begin
      wa_q.push_back(int'(a.o_ibuf_addr));
      wd_q.push_back(int'(a.o_ibuf_wr_data));
      last_wr_cyc = cyc;
    end
    if (a.o_start) st_q.push_back(cyc);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    st_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"},        a.o_ibuf_we, 0);
    chk({tag, "_addr"},      a.o_ibuf_addr, 0);
    chk({tag, "_data"},      a.o_ibuf_wr_data, 0);
    chk({tag, "_start"},     a.o_start, 0);
    chk({tag, "_next_busy"}, a.o_next_busy, 0);
    chk({tag, "_drop"},      a.o_drop, 0);
    chk({tag, "_frame_cnt"}, a.o_frame_cnt, 0);
  endtask

  task automatic send_frame(input bit gapped);
    int sent;
    int d;
    bit v;
    exp_q.delete();
    clear_mon();
    sent = 0;
    while (sent < N) begin
      v = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      d = int'($urandom_range(0, 255));
      a.i_func_valid = v;
      a.i_func_data  = 8'(d);
      if (v) begin
        exp_q.push_back(conv(s8(d), 8, 1'b0));
        sent++;
      end
      tick();
    end
    a.i_func_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_frame(input int fc);
    chk("wr_count", wa_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wa_q.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), wa_q[i], i);
      chk($sformatf("wr_data[%0d]", i), wd_q[i], exp_q[i]);
    end
    chk("start_pulses", st_q.size(), 1);
    if (st_q.size() > 0) chk("start_after_last_write", st_q[0], last_wr_cyc + 1);
    chk("frame_cnt", a.o_frame_cnt, fc);
    chk("next_busy_after_frame", a.o_next_busy, 1);
    chk("addr_hold", a.o_ibuf_addr, N - 1);
    chk("data_hold", a.o_ibuf_wr_data, exp_q[exp_q.size() - 1]);
  endtask

  task automatic release_layer();
    a.i_layer_busy = 1'b1;
    repeat (5) tick();
    chk("next_busy_layer_busy", a.o_next_busy, 1);
    a.i_layer_busy = 1'b0;
    tick();
    chk("next_busy_release", a.o_next_busy, 0);
  endtask

  initial begin
    a.i_func_valid = 1'b0; a.i_func_data = '0; a.i_layer_busy = 1'b0;
    s.i_func_valid = 1'b0; s.i_func_data = '0; s.i_layer_busy = 1'b0;
    r.i_func_valid = 1'b0; r.i_func_data = '0; r.i_layer_busy = 1'b0;

    #2;
    chk_reset_outputs("por");
    tick();
    rst = 1'b1;
    tick();

    // Saturation and ReLU on the 16-to-8 bit instances.
    for (int k = 0; k < 4; k++) begin
      s.i_func_valid = 1'b1; s.i_func_data = 16'(sat_v[k]);
      r.i_func_valid = 1'b1; r.i_func_data = 16'(sat_v[k]);
      tick();
      chk($sformatf("sat_we[%0d]", k),   s.o_ibuf_we, 1);
      chk($sformatf("sat_addr[%0d]", k), s.o_ibuf_addr, k);
      chk($sformatf("sat_data[%0d]", k), s.o_ibuf_wr_data, conv(sat_v[k], 8, 1'b0));
      chk($sformatf("relu_data[%0d]", k), r.o_ibuf_wr_data, conv(sat_v[k], 8, 1'b1));
    end
    s.i_func_valid = 1'b0;
    r.i_func_valid = 1'b0;
    chk("sat_start_not_with_last_write", s.o_start, 0);
    tick();
    chk("sat_start", s.o_start, 1);
    chk("sat_frame_cnt", s.o_frame_cnt, 1);
    chk("relu_start", r.o_start, 1);
    tick();
    chk("sat_start_single", s.o_start, 0);

    // Reset in the middle of a partial frame.
    for (int i = 0; i < 100; i++) begin
      a.i_func_valid = 1'b1;
      a.i_func_data  = 8'($urandom_range(0, 255));
      tick();
    end
    a.i_func_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    #2 rst = 1'b1;
    clear_mon();

    // Full back-to-back frame 0..255.
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      a.i_func_valid = 1'b1;
      a.i_func_data  = 8'(i);
      exp_q.push_back(conv(s8(i), 8, 1'b0));
      tick();
    end
    a.i_func_valid = 1'b0;
    repeat (3) tick();
    check_frame(1);

    // Layer slow to raise busy: no re-launch, producer stays held off.
    for (int i = 0; i < 20; i++) begin
      chk("next_busy_wait_busy", a.o_next_busy, 1);
      tick();
    end
    chk("no_second_start", st_q.size(), 1);
    a.i_layer_busy = 1'b1;
    repeat (50) tick();
    chk("next_busy_wait_done", a.o_next_busy, 1);
    chk("drop_clear", a.o_drop, 0);

    // Beats offered while held off are dropped.
    for (int i = 0; i < 3; i++) begin
      a.i_func_valid = 1'b1;
      a.i_func_data  = 8'($urandom_range(0, 255));
      tick();
    end
    a.i_func_valid = 1'b0;
    chk("drop_no_write", wa_q.size(), N);
    chk("drop_set", a.o_drop, 1);
    a.i_layer_busy = 1'b0;
    tick();
    chk("next_busy_drop_release", a.o_next_busy, 0);
    chk("drop_sticky", a.o_drop, 1);

    // Next frame starts at address 0 despite the dropped beats.
    send_frame(1'b1);
    check_frame(2);
    release_layer();

    rst = 1'b0;
    #2;
    chk_reset_outputs("reset2");
    rst = 1'b1;
    tick();

    // Three gapped random frames.
    for (int f = 1; f <= 3; f++) begin
      send_frame(1'b1);
      check_frame(f);
      release_layer();
    end
    chk("final_drop", a.o_drop, 0);
    chk("final_frame_cnt", a.o_frame_cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
